// File: rtl/comb_or_and_bist_pkg.sv
// Shared definitions for the comb_or_and self-test sequencer: FSM states,
// vector count, golden capture word and the golden function itself.
package comb_or_and_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int         NUM_VEC    = 8;
  localparam logic [7:0] EXP_RESULT = 8'hA8;

  // Expected x for vector i, where a=i[2], b=i[1], c=i[0].
  function automatic logic golden_x(input logic [2:0] i);
    return (i[2] | i[1]) & i[0];
  endfunction

endpackage

// File: rtl/comb_or_and_bist.sv
// Self-test sequencer for an external comb_or_and instance. Walks all 8
// input vectors, samples x after SETTLE_CYCLES, and reports a capture word,
// error count and pass flag. All outputs are registered.
module comb_or_and_bist
  import comb_or_and_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  input  logic       dut_x,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] result,
  output logic [3:0] err_count,
  output logic [2:0] vec_idx
);

  // Counter only ever holds SETTLE_CYCLES-1 down to 0; keep at least 1 bit.
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t        state;
  logic [CW-1:0] settle_cnt;
  logic          mismatch;
  logic [3:0]    err_next;

  // Compare the sampled x against the golden value for the applied vector.
  assign mismatch = dut_x ^ golden_x(vec_idx);
  assign err_next = err_count + {3'b000, mismatch};

  // Sequencer FSM; busy/done/pass are decided on the transition so they line
  // up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      dut_a      <= 1'b0;
      dut_b      <= 1'b0;
      dut_c      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      result     <= '0;
      err_count  <= '0;
      vec_idx    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state     <= S_APPLY;
            busy      <= 1'b1;
            vec_idx   <= '0;
            dut_a     <= 1'b0;
            dut_b     <= 1'b0;
            dut_c     <= 1'b0;
            result    <= '0;
            err_count <= '0;
            pass      <= 1'b0;
          end
        end
        S_APPLY: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else if (SETTLE_CYCLES == 0) begin
            state <= S_SAMPLE;
          end else begin
            state      <= S_SETTLE;
            settle_cnt <= CW'(SETTLE_CYCLES - 1);
          end
        end
        S_SETTLE: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else if (settle_cnt == '0) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            result[vec_idx] <= dut_x;
            err_count       <= err_next;
            if (vec_idx == 3'(NUM_VEC - 1)) begin
              // Final vector: pass must include this sample's outcome.
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 4'd0);
            end else begin
              state   <= S_APPLY;
              vec_idx <= vec_idx + 3'd1;
              {dut_a, dut_b, dut_c} <= vec_idx + 3'd1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comb_or_and_bist.sv
// Randomized self-checking bench: two sequencers (SETTLE_CYCLES=1 and 0)
// against a timeline model built from run arithmetic, plus literal pins.
module tb_comb_or_and_bist;
  import comb_or_and_bist_pkg::*;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic chk_en = 1'b0;
  logic [7:0] flip = 8'h00;   // bit i inverts the external x for vector i
  int chk_cnt = 0, pass_cnt = 0;

  always #5 clk = ~clk;

  logic a1, b1, c1, x1, busy1, done1, pass1;
  logic a0, b0, c0, x0, busy0, done0, pass0;
  logic [7:0] res1, res0;
  logic [3:0] err1, err0;
  logic [2:0] vi1, vi0;

  // External comb_or_and with optional injected faults.
  assign x1 = ((a1 | b1) & c1) ^ flip[{a1, b1, c1}];
  assign x0 = ((a0 | b0) & c0) ^ flip[{a0, b0, c0}];

  comb_or_and_bist #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_x(x1),
    .busy(busy1), .done(done1), .pass(pass1), .result(res1),
    .err_count(err1), .vec_idx(vi1));

  comb_or_and_bist #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .dut_a(a0), .dut_b(b0), .dut_c(c0), .dut_x(x0),
    .busy(busy0), .done(done0), .pass(pass0), .result(res0),
    .err_count(err0), .vec_idx(vi0));

  // Model: t counts cycles since the accepting edge; a run is 8*P busy
  // cycles (P = settle + 2), vector v is sampled at the end of cycle (v+1)*P,
  // and cycle 8*P+1 is the done cycle.
  typedef struct {
    bit         active;
    int         t;
    logic [7:0] res;
    logic [3:0] err;
    bit         pass;
    bit         done;
    logic [2:0] vidx;
  } model_t;

  model_t m1, m0;

  function automatic model_t step(input model_t m, input int p, input bit rst,
                                  input bit st, input bit ab, input logic [7:0] fl);
    model_t n;
    n = m;
    if (rst) begin
      n.active = 0; n.t = 0; n.res = 0; n.err = 0;
      n.pass = 0; n.done = 0; n.vidx = 0;
    end else if (!m.active) begin
      if (st && !ab) begin
        n.active = 1; n.t = 1; n.res = 0; n.err = 0;
        n.pass = 0; n.done = 0; n.vidx = 0;
      end
    end else if (m.t <= 8 * p && ab) begin
      n.active = 0; n.pass = 0; n.done = 0;
    end else begin
      if (m.t <= 8 * p && (m.t % p) == 0) begin
        int v;
        v = m.t / p - 1;
        n.res[v] = golden_x(3'(v)) ^ fl[v];
        n.err = n.err + {3'b000, fl[v]};
      end
      n.t = m.t + 1;
      if (n.t <= 8 * p) n.vidx = 3'((n.t - 1) / p);
      n.done = (n.t == 8 * p + 1);
      if (n.done) n.pass = (n.err == 0);
      if (n.t == 8 * p + 2) n.active = 0;
    end
    return n;
  endfunction

  function automatic bit exp_busy(input model_t m, input int p);
    return m.active && m.t >= 1 && m.t <= 8 * p;
  endfunction

  always @(posedge clk) begin
    m1 <= step(m1, 3, reset, start, abort, flip);
    m0 <= step(m0, 2, reset, start, abort, flip);
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act !== req) $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    else pass_cnt++;
  endtask

  // Cycle-by-cycle comparison of both sequencers against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy1", busy1, exp_busy(m1, 3));
      cmp("done1", done1, m1.done);
      cmp("pass1", pass1, m1.pass);
      cmp("result1", res1, m1.res);
      cmp("err1", err1, m1.err);
      cmp("vidx1", vi1, m1.vidx);
      cmp("abc1", {a1, b1, c1}, m1.vidx);
      cmp("busy0", busy0, exp_busy(m0, 2));
      cmp("done0", done0, m0.done);
      cmp("pass0", pass0, m0.pass);
      cmp("result0", res0, m0.res);
      cmp("err0", err0, m0.err);
      cmp("vidx0", vi0, m0.vidx);
      cmp("abc0", {a0, b0, c0}, m0.vidx);
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Cycle n=1 is the cycle right after the accepting edge; -1 = never seen.
  task automatic wait_run(input bit restart_mid, output int n1, output int n0,
                          output int nd1);
    n1 = -1; n0 = -1; nd1 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done1) begin nd1++; if (n1 < 0) n1 = n; end
      if (done0 && n0 < 0) n0 = n;
      if (restart_mid && n == 8) start = 1'b1;
      if (restart_mid && n == 9) start = 1'b0;
    end
  endtask

  initial begin
    int l1, l0, nd;
    bit found;
    int ab_at, rs_at;

    @(posedge clk); #1 chk_en = 1'b1;
    @(negedge clk);
    cmp("rst_result", res1, 8'h00);
    cmp("rst_abc", {a1, b1, c1, busy1, done1, pass1}, 6'b0);
    @(posedge clk); #1 reset = 1'b0;

    // Good part, both settle settings.
    flip = 8'h00;
    pulse_start();
    wait_run(0, l1, l0, nd);
    cmp("good_lat1", l1, 25);
    cmp("good_lat0", l0, 17);
    cmp("good_res1", res1, 8'hA8);
    cmp("good_err1", err1, 0);
    cmp("good_pass1", pass1, 1);
    cmp("good_res0", res0, 8'hA8);
    cmp("good_pass0", pass0, 1);
    cmp("good_abc", {a1, b1, c1}, 3'b111);

    // x stuck at 0.
    flip = EXP_RESULT;
    pulse_start();
    wait_run(0, l1, l0, nd);
    cmp("sa0_lat1", l1, 25);
    cmp("sa0_res1", res1, 8'h00);
    cmp("sa0_err1", err1, 3);
    cmp("sa0_pass1", pass1, 0);

    // x stuck at 1.
    flip = ~EXP_RESULT;
    pulse_start();
    wait_run(0, l1, l0, nd);
    cmp("sa1_res1", res1, 8'hFF);
    cmp("sa1_err1", err1, 5);
    cmp("sa1_pass1", pass1, 0);

    // Start re-asserted mid-run is ignored.
    flip = 8'h00;
    pulse_start();
    wait_run(1, l1, l0, nd);
    cmp("restart_ndone", nd, 1);
    cmp("restart_lat1", l1, 25);

    // Abort while vector 3 is applied.
    flip = ~EXP_RESULT;
    pulse_start();
    found = 0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk);
      if (m1.active && m1.vidx == 3) found = 1;
    end
    cmp("abort_reach", found, 1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    cmp("abort_busy", busy1, 0);
    cmp("abort_res", res1, 8'h07);
    cmp("abort_err", err1, 3);
    cmp("abort_pass", pass1, 0);
    nd = 0;
    repeat (30) begin @(negedge clk); if (done1 || done0) nd++; end
    cmp("abort_nodone", nd, 0);

    // start+abort together in IDLE.
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    cmp("st_ab_busy", {busy1, busy0}, 2'b00);

    // Reset mid-run, then a clean run.
    flip = 8'h00;
    pulse_start();
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cmp("mrst_out", {res1, err1, vi1, a1, b1, c1, busy1, done1, pass1}, 0);
    pulse_start();
    wait_run(0, l1, l0, nd);
    cmp("mrst_lat1", l1, 25);
    cmp("mrst_res1", res1, 8'hA8);
    cmp("mrst_pass1", pass1, 1);

    // Randomized runs: fault masks, stray starts, aborts and resets.
    for (int it = 0; it < 25; it++) begin
      flip = 8'($urandom);
      pulse_start();
      ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 26)) : 0;
      rs_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 26)) : 0;
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        abort = (n == ab_at);
        reset = (n == rs_at);
        start = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      start = 1'b0; abort = 1'b0; reset = 1'b0;
      repeat (30) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/comb_or_and_bist.md
Name: comb_or_and_bist

Overview:
Self-test sequencer for the comb_or_and datapath, whose function is x = (a | b) & c. On a start request it drives all 8 input vectors into an external comb_or_and instance and samples x after a programmable settle time. It compares each sample against the golden value and reports a per-vector capture word, an error count and a pass flag. It replaces hand-written delay-driven stimulus with a clocked, repeatable check usable on hardware.

Parameters:
SETTLE_CYCLES, 1, wait cycles between driving a vector and sampling dut_x (0 is legal: sample directly after APPLY)

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high reset
start  input  1  run request, sampled only in IDLE
abort  input  1  cancel a run in progress
dut_a  output  1  drive to comb_or_and a
dut_b  output  1  drive to comb_or_and b
dut_c  output  1  drive to comb_or_and c
dut_x  input  1  comb_or_and x
busy  output  1  high while a run is in progress (APPLY/SETTLE/SAMPLE)
done  output  1  one-cycle pulse when a run completes normally
pass  output  1  result of last completed run: 1 when err_count == 0
result  output  8  result[i] = dut_x sampled for vector i
err_count  output  4  number of mismatching vectors, 0..8
vec_idx  output  3  index of the vector currently applied

Behaviour:
- Reset (synchronous, active-high, wins over everything): state IDLE. All outputs are 0: dut_a/b/c, busy, done, pass, result, err_count, vec_idx. The settle counter is 0.
- Vector mapping: dut_a = vec_idx[2], dut_b = vec_idx[1], dut_c = vec_idx[0]. All three are registered outputs, changing only on APPLY entry.
- Golden: exp(i) = (i[2] | i[1]) & i[0]. This gives expected result 8'hA8.
- States: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE: if start=1 and abort=0, go to APPLY. On that transition set vec_idx=0 and clear result, err_count and pass. Otherwise stay; all registers hold.
- APPLY: one cycle, vector already driven. Go to SETTLE with the counter loaded to SETTLE_CYCLES-1; if SETTLE_CYCLES=0, go straight to SAMPLE.
- SETTLE: decrement the counter; when the counter is 0, go to SAMPLE.
- SAMPLE: one cycle. Set result[vec_idx] <= dut_x. If dut_x != exp(vec_idx), err_count <= err_count+1.
  - If vec_idx==7, go to DONE.
  - Otherwise vec_idx <= vec_idx+1, drive the new vector, and go to APPLY.
- DONE: one cycle. done=1 and pass <= (final err_count == 0), including the SAMPLE update of vector 7. Then go to IDLE. vec_idx stays at 7 and dut_a/b/c hold 1,1,1 until the next start.
- busy = 1 in APPLY, SETTLE and SAMPLE only.
- Latency:
  - Start is accepted at edge k and APPLY is active in cycle k+1.
  - The run occupies 8*(SETTLE_CYCLES+2) cycles, then DONE is active for one cycle.
  - With the default SETTLE_CYCLES=1, done is high 25 cycles after the accepting edge.
- Abort: in APPLY, SETTLE or SAMPLE, abort=1 sends the FSM to IDLE on the next edge.
  - No done pulse and no SAMPLE update in that cycle.
  - pass <= 0; result and err_count keep their partial values.
  - abort in IDLE or DONE has no effect, except that in IDLE it blocks a simultaneous start.
- start while busy or in DONE is ignored; there is no queuing. A new run needs start in IDLE.
- err_count saturation is impossible (maximum 8 fits in 4 bits).
- Reset mid-run behaves exactly as reset from power-up.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, APPLY, SETTLE, SAMPLE, DONE);
  - constant NUM_VEC = 8;
  - constant EXP_RESULT = 8'hA8;
  - the golden function exp(i), so the bench and RTL share one definition.
- No sub-module: the settle counter and FSM stay inline.
- The comb_or_and instance sits outside this block, alongside it in the parent.

Test Plan:
- Good DUT, SETTLE_CYCLES=1, start pulse -> busy for 24 cycles, done pulse on cycle 25, result=8'hA8, err_count=0, pass=1.
- dut_x tied 0 -> result=8'h00, err_count=3, pass=0, done on cycle 25.
- dut_x tied 1 -> result=8'hFF, err_count=5, pass=0.
- SETTLE_CYCLES=0, good DUT -> done on cycle 17, result=8'hA8, pass=1.
- Abort asserted while vec_idx=3 -> IDLE next edge, busy=0, no done, pass=0, result[7:3]=0, err_count reflects vectors 0..2 only.
- Other start and reset cases:
  - start asserted again mid-run -> ignored, single done at cycle 25.
  - start and abort together in IDLE -> stays IDLE.
  - reset mid-run -> all outputs 0 on the next cycle; a fresh start then completes normally.
